cnn_layer_accel_result_packer: RTL and testbench

// - Downstream of cnn_layer_accel_quad. Consumes the 16-bit result stream (result_valid/result_accept/result_data).
// - Packs C_LANES results per output word, little-endian: first result in lane 0 = bits [15:0].
// - Emits 128-bit words to the memory-write path with a last flag and a lane keep mask.
// - Tracks a per-job result count; pads the final partial word and pulses job_done.

---
 rtl/cnn_layer_accel_result_packer.sv | 199 +++++++++++++++++++
 tb/tb_cnn_layer_accel_result_packer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_layer_accel_result_packer
//  Description : Packs the 16-bit quad result stream into C_LANES-wide output
//                words (lane 0 = first result, little-endian), with keep mask,
//                last flag, per-job result counting, padding of the final
//                partial word and a job_done pulse.
//                Optional build macro CNL_RESULT_PACK_RELU_EN clamps negative
//                results to zero before they are packed.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_layer_accel_result_packer #(
    parameter int C_LANES     = 8,
    parameter int C_CNT_WIDTH = 24
) (
    input  logic                     clk_if,
    input  logic                     rst,
    input  logic                     job_start,
    input  logic [C_CNT_WIDTH-1:0]   job_num_results,
    input  logic                     result_valid,
    output logic                     result_accept,
    input  logic [15:0]              result_data,
    output logic                     pack_valid,
    input  logic                     pack_ready,
    output logic [16*C_LANES-1:0]    pack_data,
    output logic [C_LANES-1:0]       pack_keep,
    output logic                     pack_last,
    output logic                     job_done
);

    // Lane counter must also hold C_LANES (a fully filled word parked as pending).
    localparam int LANE_W = $clog2(C_LANES) + 1;
    localparam int WORD_W = 16 * C_LANES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_W-1:0]      acc_q, acc_d;
    logic [LANE_W-1:0]      lane_cnt_q, lane_cnt_d;
    logic [C_CNT_WIDTH-1:0] remain_q, remain_d;
    logic                   pend_q, pend_d;
    logic                   pack_valid_q, pack_valid_d;
    logic [WORD_W-1:0]      pack_data_q, pack_data_d;
    logic [C_LANES-1:0]     pack_keep_q, pack_keep_d;
    logic                   pack_last_q, pack_last_d;

    logic [15:0]            lane_in;
    logic [WORD_W-1:0]      acc_new;
    logic                   slot_free;
    logic                   accept_fire;
    logic                   final_result;
    logic                   word_complete;
    logic [LANE_W-1:0]      lanes_filled;

    // Lane mask with the lowest 'filled' bits set.
    function automatic logic [C_LANES-1:0] keep_mask(input logic [LANE_W-1:0] filled);
        logic [C_LANES-1:0] m;
        for (int i = 0; i < C_LANES; i++) begin
            m[i] = (LANE_W'(i) < filled);
        end
        return m;
    endfunction

`ifdef CNL_RESULT_PACK_RELU_EN
    // Negative results are clamped to zero before packing.
    assign lane_in = result_data[15] ? 16'h0000 : result_data;
`else
    assign lane_in = result_data;
`endif

    assign result_accept = (state_q == S_PACK) && !pend_q;
    assign accept_fire   = result_valid && result_accept;
    assign slot_free     = !pack_valid_q || pack_ready;
    assign final_result  = (remain_q == C_CNT_WIDTH'(1));
    assign word_complete = (lane_cnt_q == LANE_W'(C_LANES - 1)) || final_result;
    assign lanes_filled  = lane_cnt_q + LANE_W'(1);

    assign pack_valid = pack_valid_q;
    assign pack_data  = pack_data_q;
    assign pack_keep  = pack_keep_q;
    assign pack_last  = pack_last_q;
    assign job_done   = (state_q == S_DONE);

    // Accumulator image with the incoming result dropped into the current lane.
    always_comb begin
        acc_new = acc_q;
        for (int i = 0; i < C_LANES; i++) begin
            if (lane_cnt_q == LANE_W'(i)) begin
                acc_new[i*16 +: 16] = lane_in;
            end
        end
    end

    // Next-state: job sequencing, lane filling, pending-word parking and output slot.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        lane_cnt_d   = lane_cnt_q;
        remain_d     = remain_q;
        pend_d       = pend_q;
        pack_valid_d = pack_valid_q;
        pack_data_d  = pack_data_q;
        pack_keep_d  = pack_keep_q;
        pack_last_d  = pack_last_q;

        // Handshake empties the slot; a load below in the same cycle overrides.
        if (pack_valid_q && pack_ready) begin
            pack_valid_d = 1'b0;
            pack_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    if (job_num_results != '0) begin
                        state_d  = S_PACK;
                        remain_d = job_num_results;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (pack_valid_q && pack_ready && pack_last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
            end
        endcase

        // A parked word moves out as soon as the slot frees. lane_cnt_q holds
        // its filled-lane count; remain has already reached zero if it is final.
        if (pend_q && slot_free) begin
            pack_valid_d = 1'b1;
            pack_data_d  = acc_q;
            pack_keep_d  = keep_mask(lane_cnt_q);
            pack_last_d  = (remain_q == '0);
            acc_d        = '0;
            lane_cnt_d   = '0;
            pend_d       = 1'b0;
        end

        // Accept never overlaps a pending move since accept requires !pend_q.
        if (accept_fire) begin
            remain_d = remain_q - C_CNT_WIDTH'(1);
            if (word_complete && slot_free) begin
                pack_valid_d = 1'b1;
                pack_data_d  = acc_new;
                pack_keep_d  = keep_mask(lanes_filled);
                pack_last_d  = final_result;
                acc_d        = '0;
                lane_cnt_d   = '0;
            end else begin
                acc_d      = acc_new;
                lane_cnt_d = lanes_filled;
                pend_d     = word_complete;
            end
            if (final_result) begin
                state_d = S_WAIT;
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            lane_cnt_q   <= '0;
            remain_q     <= '0;
            pend_q       <= 1'b0;
            pack_valid_q <= 1'b0;
            pack_data_q  <= '0;
            pack_keep_q  <= '0;
            pack_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            lane_cnt_q   <= lane_cnt_d;
            remain_q     <= remain_d;
            pend_q       <= pend_d;
            pack_valid_q <= pack_valid_d;
            pack_data_q  <= pack_data_d;
            pack_keep_q  <= pack_keep_d;
            pack_last_q  <= pack_last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_layer_accel_result_packer
//  Description : Scoreboard bench for cnn_layer_accel_result_packer. Stimulus
//                queues results and expected words; a monitor pops and checks
//                every handshaken word and the job_done pulse timing.
//                Honours CNL_RESULT_PACK_RELU_EN for the clamp test.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_layer_accel_result_packer;

    localparam int C_LANES = 8;
    localparam int CW      = 24;
    localparam int WW      = 16 * C_LANES;

    logic            clk_if = 1'b0;
    logic            rst;
    logic            job_start;
    logic [CW-1:0]   job_num_results;
    logic            result_valid;
    logic            result_accept;
    logic [15:0]     result_data;
    logic            pack_valid;
    logic            pack_ready;
    logic [WW-1:0]   pack_data;
    logic [C_LANES-1:0] pack_keep;
    logic            pack_last;
    logic            job_done;

    cnn_layer_accel_result_packer #(.C_LANES(C_LANES), .C_CNT_WIDTH(CW)) dut (
        .clk_if          (clk_if),
        .rst             (rst),
        .job_start       (job_start),
        .job_num_results (job_num_results),
        .result_valid    (result_valid),
        .result_accept   (result_accept),
        .result_data     (result_data),
        .pack_valid      (pack_valid),
        .pack_ready      (pack_ready),
        .pack_data       (pack_data),
        .pack_keep       (pack_keep),
        .pack_last       (pack_last),
        .job_done        (job_done)
    );

    always #5 clk_if = ~clk_if;

    typedef struct {
        logic [WW-1:0]      data;
        logic [C_LANES-1:0] keep;
        logic               last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] src_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int accepted = 0;
    int done_seen = 0;
    int done_target = 0;
    int exp_done_cyc = -10;

    always @(posedge clk_if) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef CNL_RESULT_PACK_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    // Queue n sequential results first..first+n-1 and the words they form.
    task automatic push_job(input int first, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) src_q.push_back(16'(first + k));
        for (int b = 0; b < n; b += C_LANES) begin
            e.data = '0;
            e.keep = '0;
            for (int l = 0; l < C_LANES && (b + l) < n; l++) begin
                e.data[l*16 +: 16] = relu(16'(first + b + l));
                e.keep[l] = 1'b1;
            end
            e.last = ((b + C_LANES) >= n);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_job(input int n);
        @(posedge clk_if); #1;
        job_start       = 1'b1;
        job_num_results = CW'(n);
        if (n == 0) exp_done_cyc = cyc + 1;
        @(posedge clk_if); #1;
        job_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || done_seen < done_target) && t < 2000) begin
            @(posedge clk_if);
            t++;
        end
        check({name, "_timeout"}, WW'(t >= 2000), WW'(0));
        repeat (2) @(posedge clk_if);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_accept"}, WW'(result_accept), WW'(0));
        check({tag, "_valid"},  WW'(pack_valid),    WW'(0));
        check({tag, "_last"},   WW'(pack_last),     WW'(0));
        check({tag, "_done"},   WW'(job_done),      WW'(0));
        check({tag, "_data"},   pack_data,          WW'(0));
        check({tag, "_keep"},   WW'(pack_keep),     WW'(0));
    endtask

    // Result source: presents the head of src_q, pops on each accepted beat.
    initial begin
        logic hs;
        result_valid = 1'b0;
        result_data  = '0;
        forever begin
            @(negedge clk_if);
            hs = result_valid && result_accept;
            @(posedge clk_if); #1;
            if (hs && src_q.size() > 0) begin
                void'(src_q.pop_front());
                accepted++;
            end
            if (rst) src_q.delete();
            if (src_q.size() > 0) begin
                result_valid = 1'b1;
                result_data  = src_q[0];
            end else begin
                result_valid = 1'b0;
                result_data  = '0;
            end
        end
    end

    // Monitor: checks handshaken words, stall stability and job_done timing.
    initial begin
        exp_t          e;
        logic          stalled_prev = 1'b0;
        logic [WW-1:0] held_data = '0;
        logic          exp_done;
        forever begin
            @(negedge clk_if);
            if (rst) begin
                stalled_prev = 1'b0;
            end else begin
                if (stalled_prev) begin
                    check("stall_valid_hold", WW'(pack_valid), WW'(1));
                    check("stall_data_hold",  pack_data,       held_data);
                end
                if (pack_valid && pack_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", WW'(1), WW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", pack_data,       e.data);
                        check("word_keep", WW'(pack_keep),  WW'(e.keep));
                        check("word_last", WW'(pack_last),  WW'(e.last));
                    end
                    if (pack_last) exp_done_cyc = cyc + 1;
                end
                stalled_prev = pack_valid && !pack_ready;
                held_data    = pack_data;
                exp_done     = (cyc == exp_done_cyc);
                if (job_done || exp_done) begin
                    check("job_done_timing", WW'(job_done), WW'(exp_done));
                    if (job_done) done_seen++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   t;
        rst             = 1'b1;
        job_start       = 1'b0;
        job_num_results = '0;
        pack_ready      = 1'b1;
        repeat (2) @(posedge clk_if);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // 16 results, ready high: two full words, last on the second only.
        push_job(1, 16);
        done_target++;
        start_job(16);
        wait_done("job16");

        // 11 results: second word padded, keep 07.
        for (int k = 1; k <= 11; k++) src_q.push_back(16'(k));
        e.data = 128'h0008_0007_0006_0005_0004_0003_0002_0001; e.keep = 8'hFF; e.last = 1'b0;
        exp_q.push_back(e);
        e.data = 128'h0000_0000_0000_0000_0000_000B_000A_0009; e.keep = 8'h07; e.last = 1'b1;
        exp_q.push_back(e);
        done_target++;
        start_job(11);
        wait_done("job11");

        // Downstream stalled for 30 cycles with 24 results offered.
        pack_ready = 1'b0;
        accepted   = 0;
        push_job(100, 24);
        done_target++;
        start_job(24);
        repeat (30) @(posedge clk_if);
        #2;
        check("stall_accepted_count", WW'(accepted), WW'(16));
        check("stall_accept_low",     WW'(result_accept), WW'(0));
        pack_ready = 1'b1;
        wait_done("job24_stall");

        // Zero-count job, then a normal job.
        done_target++;
        start_job(0);
        repeat (3) @(posedge clk_if);
        check("zero_job_done_seen", WW'(done_seen), WW'(done_target));
        push_job(200, 8);
        done_target++;
        start_job(8);
        wait_done("job8_after_zero");

        // Reset after 5 of 16 results, then an 8-result job.
        accepted = 0;
        push_job(300, 16);
        start_job(16);
        t = 0;
        while (accepted < 5 && t < 200) begin
            @(posedge clk_if); #2;
            t++;
        end
        check("rst_wait_timeout", WW'(t >= 200), WW'(0));
        rst = 1'b1;
        exp_q.delete();
        src_q.delete();
        @(posedge clk_if); #1;
        check_reset_outputs("midjob_reset");
        rst = 1'b0;
        push_job(400, 8);
        done_target++;
        start_job(8);
        wait_done("job8_after_reset");

        // Negative result clamped only in the ReLU build.
        src_q.push_back(16'h8001);
        src_q.push_back(16'h0005);
`ifdef CNL_RESULT_PACK_RELU_EN
        e.data = 128'h0000_0000_0000_0000_0000_0000_0005_0000;
`else
        e.data = 128'h0000_0000_0000_0000_0000_0000_0005_8001;
`endif
        e.keep = 8'h03;
        e.last = 1'b1;
        exp_q.push_back(e);
        done_target++;
        start_job(2);
        wait_done("relu_job");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
